// File: rtl/ahb_dp_resp_mux.sv
// ahb_dp_resp_mux: AHB data-phase response multiplexer with a built-in default slave.
// Captures the decoder's one-hot address-phase select on each HREADY-qualified
// edge. It steers the selected slave's response back to the master. Unmapped or
// multi-hot selects on active transfers get a two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESETn - bus clock (rising edge), asynchronous active-low reset
//   sel_ap        - address-phase slave select from the decoder (one-hot or zero)
//   htrans        - address-phase HTRANS; bit 1 marks NONSEQ/SEQ
//   hready_in     - bus HREADY (externally tied to payload_out[0])
//   payload_in    - packed per-slave {HRDATA, HRESP, HREADYOUT}
//   payload_out   - response to the master (combinational from state and payload_in)
//   sel_dp        - registered data-phase select
//   sel_err       - one-cycle pulse after a multi-hot select is captured
module ahb_dp_resp_mux #(
  parameter int unsigned CHANNEL_NUM = 7,
  parameter int unsigned PAYLOAD     = 34
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [CHANNEL_NUM-1:0]         sel_ap,
  input  logic [1:0]                     htrans,
  input  logic                           hready_in,
  input  logic [CHANNEL_NUM*PAYLOAD-1:0] payload_in,
  output logic [PAYLOAD-1:0]             payload_out,
  output logic [CHANNEL_NUM-1:0]         sel_dp,
  output logic                           sel_err
);

  localparam int unsigned CW = CHANNEL_NUM;
  localparam int unsigned PW = PAYLOAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] sel_dp_q, sel_dp_d;
  logic          sel_err_q, sel_err_d;

  logic active;
  logic sel_zero;
  logic sel_onehot;
  logic sel_multi;
  logic unused_htrans0;

  // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  assign active         = htrans[1];
  assign unused_htrans0 = htrans[0];

  // x & (x-1) clears the lowest set bit, so it is zero iff at most one bit is set.
  assign sel_zero   = (sel_ap == '0);
  assign sel_onehot = !sel_zero && ((sel_ap & (sel_ap - CW'(1))) == '0);
  assign sel_multi  = !sel_zero && !sel_onehot;

  // State and data-phase select registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      sel_dp_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_dp_q  <= sel_dp_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Next-state and capture logic; ERR1 always advances since it drives HREADYOUT low.
  always_comb begin
    state_d   = state_q;
    sel_dp_d  = sel_dp_q;
    sel_err_d = 1'b0;
    case (state_q)
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_IDLE, ST_ERR2: begin
        if (hready_in) begin
          if (active && sel_onehot) begin
            sel_dp_d = sel_ap;
            state_d  = ST_IDLE;
          end else if (active) begin
            sel_dp_d  = '0;
            state_d   = ST_ERR1;
            sel_err_d = sel_multi;
          end else begin
            sel_dp_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_dp_d = '0;
      end
    endcase
  end

  // Response mux; sel_dp is one-hot, so OR-ing the selected channels is exact.
  always_comb begin
    logic [PW-1:0] mux;
    mux = '0;
    for (int i = 0; i < int'(CW); i++) begin
      if (sel_dp_q[i]) begin
        mux = mux | payload_in[i*PW +: PW];
      end
    end
    if (sel_dp_q != '0) begin
      payload_out = mux;
    end else begin
      case (state_q)
        ST_ERR1: payload_out = PW'(2);
        ST_ERR2: payload_out = PW'(3);
        default: payload_out = PW'(1);
      endcase
    end
  end

  assign sel_dp  = sel_dp_q;
  assign sel_err = sel_err_q;

endmodule
